// File: rtl/vx_issue_sched_pkg.sv
// Shared definitions for the warp issue scheduler: execute-unit type codes,
// execute-unit count, warp-id width helper and performance counter width.
package vx_issue_sched_pkg;

  localparam logic [2:0] EX_ALU = 3'd0;
  localparam logic [2:0] EX_LSU = 3'd1;
  localparam logic [2:0] EX_CSR = 3'd2;
  localparam logic [2:0] EX_FPU = 3'd3;
  localparam logic [2:0] EX_GPU = 3'd4;

  localparam int NUM_EX        = 5;
  localparam int PERF_CTR_BITS = 32;

  // Width of a warp id; a single warp still gets a 1-bit field.
  function automatic int wid_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vx_rr_pick.sv
// Combinational rotate-priority picker: grants the first requester found
// scanning upward from ptr, wrapping from N-1 back to 0. N must be a power of
// two so the index wraps by plain truncation.
module vx_rr_pick #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic          valid
);

  logic [PW-1:0] idx;

  // Scan requesters from the pointer upward and keep the first hit.
  always_comb begin
    // NOTE: every variable gets a default before the loop so no path leaves it unassigned (no latch).
    grant = '0;
    valid = 1'b0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      idx = ptr + PW'(i);
      if (!valid && req[idx]) begin
        grant[idx] = 1'b1;
        valid      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vx_issue_sched.sv
// Per-core warp issue scheduler. Picks one eligible warp per cycle (round-robin
// with a starvation override), pops its instruction-buffer head and loads it
// into a one-entry issue register handed to dispatch with valid/ready.
// Optional performance counters are enabled by defining ISSUE_SCHED_PERF_EN.
module vx_issue_sched
  import vx_issue_sched_pkg::*;
#(
  parameter int NUM_WARPS    = 4,
  parameter int EX_BITS      = 3,
  parameter int NUM_EX       = vx_issue_sched_pkg::NUM_EX,
  parameter int STARVE_LIMIT = 15
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_WARPS-1:0]           head_valid,
  input  logic [NUM_WARPS*EX_BITS-1:0]   head_ex_type,
  input  logic [NUM_WARPS-1:0]           sb_ready,
  input  logic [NUM_EX-1:0]              eu_ready,
  output logic [NUM_WARPS-1:0]           head_pop,
  output logic                           issue_valid,
  output logic [wid_bits(NUM_WARPS)-1:0] issue_wid,
  output logic [EX_BITS-1:0]             issue_ex_type,
  input  logic                           issue_ready,
  output logic                           starve_active
`ifdef ISSUE_SCHED_PERF_EN
  ,
  output logic [PERF_CTR_BITS-1:0]       perf_sb_stalls,
  output logic [PERF_CTR_BITS-1:0]       perf_eu_stalls,
  output logic [PERF_CTR_BITS-1:0]       perf_issued
`endif
);

  localparam int         WID_W      = wid_bits(NUM_WARPS);
  localparam logic [7:0] STARVE_CNT = 8'(STARVE_LIMIT);

  logic [NUM_WARPS-1:0] elig;
  logic [NUM_WARPS-1:0] rr_grant;
  logic                 rr_valid;
  logic [NUM_WARPS-1:0] starve_grant;
  logic                 starve_hit;
  logic [NUM_WARPS-1:0] sel_grant;
  logic                 sel_valid;
  logic [WID_W-1:0]     sel_wid;
  logic [EX_BITS-1:0]   sel_ex;
  logic                 load;
  logic [WID_W-1:0]     rr_ptr;
  logic [7:0]           wait_cnt [NUM_WARPS];

  // Eligibility: valid head, hazard-free, and its execute unit is ready.
  // Type codes outside the execute-unit range never match and stay ineligible.
  always_comb begin
    elig = '0;
    for (int w = 0; w < NUM_WARPS; w++) begin
      logic eu_ok;
      eu_ok = 1'b0;
      for (int e = 0; e < NUM_EX; e++) begin
        if (head_ex_type[w*EX_BITS +: EX_BITS] == EX_BITS'(e)) eu_ok = eu_ready[e];
      end
      elig[w] = head_valid[w] & sb_ready[w] & eu_ok;
    end
  end

  vx_rr_pick #(
    .N  (NUM_WARPS),
    .PW (WID_W)
  ) u_rr_pick (
    .req   (elig),
    .ptr   (rr_ptr),
    .grant (rr_grant),
    .valid (rr_valid)
  );

  // Starvation override: lowest-index eligible warp whose wait hit the limit.
  always_comb begin
    starve_grant = '0;
    starve_hit   = 1'b0;
    for (int w = 0; w < NUM_WARPS; w++) begin
      if (!starve_hit && elig[w] && (wait_cnt[w] >= STARVE_CNT)) begin
        starve_grant[w] = 1'b1;
        starve_hit      = 1'b1;
      end
    end
  end

  assign load      = !issue_valid || issue_ready;
  assign sel_valid = load && rr_valid;
  assign sel_grant = starve_hit ? starve_grant : rr_grant;
  assign head_pop  = (sel_valid && !reset) ? sel_grant : '0;

  // Encode the one-hot selection into a warp id and capture its execute type.
  always_comb begin
    sel_wid = '0;
    sel_ex  = '0;
    for (int w = 0; w < NUM_WARPS; w++) begin
      if (sel_grant[w]) begin
        sel_wid = WID_W'(w);
        sel_ex  = head_ex_type[w*EX_BITS +: EX_BITS];
      end
    end
  end

  // Issue register and round-robin pointer: load on select, drop on drain, hold otherwise.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (reset) begin
      issue_valid   <= 1'b0;
      issue_wid     <= '0;
      issue_ex_type <= '0;
      starve_active <= 1'b0;
      rr_ptr        <= '0;
    end else if (sel_valid) begin
      issue_valid   <= 1'b1;
      issue_wid     <= sel_wid;
      issue_ex_type <= sel_ex;
      starve_active <= starve_hit;
      if (!starve_hit) rr_ptr <= sel_wid + WID_W'(1);
    end else if (load) begin
      issue_valid   <= 1'b0;
      starve_active <= 1'b0;
    end
  end

  // Per-warp wait counters: clear when served or ineligible, else count up and saturate.
  always_ff @(posedge clk) begin
    for (int w = 0; w < NUM_WARPS; w++) begin
      if (reset || !elig[w] || (sel_valid && sel_grant[w])) begin
        wait_cnt[w] <= '0;
      end else if (wait_cnt[w] != 8'hFF) begin
        wait_cnt[w] <= wait_cnt[w] + 8'd1;
      end
    end
  end

`ifdef ISSUE_SCHED_PERF_EN
  logic any_hv;
  logic any_hs;
  assign any_hv = |head_valid;
  assign any_hs = |(head_valid & sb_ready);

  // Stall and issue counters, sampled only on cycles that could load.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_sb_stalls <= '0;
      perf_eu_stalls <= '0;
      perf_issued    <= '0;
    end else begin
      if (load && any_hv && !any_hs)   perf_sb_stalls <= perf_sb_stalls + 1'b1;
      if (load && any_hs && !(|elig))  perf_eu_stalls <= perf_eu_stalls + 1'b1;
      if (sel_valid)                   perf_issued    <= perf_issued + 1'b1;
    end
  end
`else
  // Performance counters compiled out.
`endif

endmodule

// File: tb/tb_vx_issue_sched.sv
// Directed testbench for vx_issue_sched: round-robin order, scoreboard stall,
// dispatch hold, execute-unit back-pressure, starvation override, invalid
// execute types and mid-operation reset.
module tb_vx_issue_sched;
  import vx_issue_sched_pkg::*;

  localparam int NW  = 4;
  localparam int EXB = 3;

  logic            clk = 1'b0;
  logic            reset;
  logic [NW-1:0]   head_valid;
  logic [NW*EXB-1:0] head_ex_type;
  logic [NW-1:0]   sb_ready;
  logic [NUM_EX-1:0] eu_ready;
  logic [NW-1:0]   head_pop;
  logic            issue_valid;
  logic [1:0]      issue_wid;
  logic [EXB-1:0]  issue_ex_type;
  logic            issue_ready;
  logic            starve_active;
`ifdef ISSUE_SCHED_PERF_EN
  logic [PERF_CTR_BITS-1:0] perf_sb_stalls;
  logic [PERF_CTR_BITS-1:0] perf_eu_stalls;
  logic [PERF_CTR_BITS-1:0] perf_issued;
`endif

  int checks = 0;
  int errors = 0;

  vx_issue_sched #(
    .NUM_WARPS    (NW),
    .EX_BITS      (EXB),
    .NUM_EX       (NUM_EX),
    .STARVE_LIMIT (15)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .head_valid    (head_valid),
    .head_ex_type  (head_ex_type),
    .sb_ready      (sb_ready),
    .eu_ready      (eu_ready),
    .head_pop      (head_pop),
    .issue_valid   (issue_valid),
    .issue_wid     (issue_wid),
    .issue_ex_type (issue_ex_type),
    .issue_ready   (issue_ready),
    .starve_active (starve_active)
`ifdef ISSUE_SCHED_PERF_EN
    ,
    .perf_sb_stalls (perf_sb_stalls),
    .perf_eu_stalls (perf_eu_stalls),
    .perf_issued    (perf_issued)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_regs(input string tag, input int v, input int wid, input int ex, input int st);
    check({tag, "_valid"},  32'(issue_valid),   32'(v));
    check({tag, "_wid"},    32'(issue_wid),     32'(wid));
    check({tag, "_ex"},     32'(issue_ex_type), 32'(ex));
    check({tag, "_starve"}, 32'(starve_active), 32'(st));
  endtask

  task automatic set_types(input logic [2:0] t0, input logic [2:0] t1,
                           input logic [2:0] t2, input logic [2:0] t3);
    head_ex_type = {t3, t2, t1, t0};
  endtask

  // Inputs change and outputs are sampled on the falling edge; head_pop is
  // sampled 1 time unit after the inputs settle.
  initial begin
    reset = 1'b1; head_valid = '0; head_ex_type = '0; sb_ready = '0;
    eu_ready = '0; issue_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk_regs("reset", 0, 0, 0, 0);
    set_types(EX_ALU, EX_LSU, EX_CSR, EX_FPU);
    head_valid = 4'hF; sb_ready = 4'hF; eu_ready = 5'h1F; issue_ready = 1'b1;
    #1 check("pop_in_reset", 32'(head_pop), 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // Round-robin over four eligible warps, back-to-back
    for (int k = 0; k < 8; k++) begin
      #1 check("t1_pop", 32'(head_pop), 32'(1 << (k % 4)));
      @(negedge clk);
      chk_regs("t1_issue", 1, k % 4, k % 4, 0);
    end
    head_valid = 4'h0;
    #1 check("t1_drain_pop", 32'(head_pop), 32'h0);
    @(negedge clk);
    check("t1_drain_valid", 32'(issue_valid), 32'h0);

    // Scoreboard stall on warp 2 for three cycles
    head_valid = 4'b0100; sb_ready = 4'b1011;
    for (int k = 0; k < 3; k++) begin
      #1 check("t2_stall_pop", 32'(head_pop), 32'h0);
      @(negedge clk);
      check("t2_stall_valid", 32'(issue_valid), 32'h0);
    end
    sb_ready = 4'hF;
`ifdef ISSUE_SCHED_PERF_EN
    check("t2_perf_sb", 32'(perf_sb_stalls), 32'd3);
`endif
    #1 check("t2_pop", 32'(head_pop), 32'b0100);
    @(negedge clk);
    chk_regs("t2_issue", 1, 2, 2, 0);
`ifdef ISSUE_SCHED_PERF_EN
    check("t2_perf_issued", 32'(perf_issued), 32'd9);
`endif

    // Dispatch hold for five cycles, then resume from the old pointer (3)
    issue_ready = 1'b0; head_valid = 4'hF;
    for (int k = 0; k < 5; k++) begin
      #1 check("t3_hold_pop", 32'(head_pop), 32'h0);
      @(negedge clk);
      chk_regs("t3_hold", 1, 2, 2, 0);
    end
    issue_ready = 1'b1;
    #1 check("t3_resume_pop", 32'(head_pop), 32'b1000);
    @(negedge clk);
    chk_regs("t3_resume", 1, 3, 3, 0);
    head_valid = 4'h0;
    @(negedge clk);
    check("t3_drain_valid", 32'(issue_valid), 32'h0);

    // LSU busy: warp 1 blocked while warps 0/2 alternate
    set_types(EX_ALU, EX_LSU, EX_ALU, EX_ALU);
    head_valid = 4'b0111; eu_ready = 5'b11101;
    for (int k = 0; k < 6; k++) begin
      #1 check("t4_pop", 32'(head_pop), 32'(1 << ((k % 2) * 2)));
      @(negedge clk);
      chk_regs("t4_issue", 1, (k % 2) * 2, 0, 0);
    end
    eu_ready = 5'h1F;
    #1 check("t4_lsu_pop0", 32'(head_pop), 32'b0001);
    @(negedge clk);
    chk_regs("t4_lsu_a", 1, 0, 0, 0);
    #1 check("t4_lsu_pop1", 32'(head_pop), 32'b0010);
    @(negedge clk);
    chk_regs("t4_lsu_b", 1, 1, 1, 0);
    head_valid = 4'h0;
    @(negedge clk);
    check("t4_drain_valid", 32'(issue_valid), 32'h0);

    // Starvation: warp 3 waits 15 hold cycles, then beats RR pointer 1
    set_types(EX_ALU, EX_LSU, EX_CSR, EX_FPU);
    head_valid = 4'b0001;
    #1 check("t5_pre_pop", 32'(head_pop), 32'b0001);
    @(negedge clk);
    chk_regs("t5_pre", 1, 0, 0, 0);
    issue_ready = 1'b0; head_valid = 4'b1000;
    for (int k = 0; k < 15; k++) begin
      #1 check("t5_hold_pop", 32'(head_pop), 32'h0);
      @(negedge clk);
      chk_regs("t5_hold", 1, 0, 0, 0);
    end
    issue_ready = 1'b1; head_valid = 4'b1010;
    #1 check("t5_starve_pop", 32'(head_pop), 32'b1000);
    @(negedge clk);
    chk_regs("t5_starve", 1, 3, 3, 1);
    head_valid = 4'b0101;
    #1 check("t5_ptr_pop", 32'(head_pop), 32'b0100);
    @(negedge clk);
    chk_regs("t5_ptr", 1, 2, 2, 0);
    head_valid = 4'h0;
    @(negedge clk);
    check("t5_drain_valid", 32'(issue_valid), 32'h0);

    // Execute types outside the unit range are never eligible
    head_valid = 4'b0001;
    set_types(3'd5, EX_LSU, EX_CSR, EX_FPU);
    #1 check("t6_type5_pop", 32'(head_pop), 32'h0);
    @(negedge clk);
    set_types(3'd7, EX_LSU, EX_CSR, EX_FPU);
    #1 check("t6_type7_pop", 32'(head_pop), 32'h0);
    @(negedge clk);
    check("t6_valid", 32'(issue_valid), 32'h0);
`ifdef ISSUE_SCHED_PERF_EN
    check("t6_perf_eu", 32'(perf_eu_stalls), 32'd2);
`endif

    // Reset while the issue register is occupied and the pointer is non-zero
    set_types(EX_ALU, EX_LSU, EX_CSR, EX_FPU);
    head_valid = 4'hF;
    #1 check("t7_pop3", 32'(head_pop), 32'b1000);
    @(negedge clk);
    chk_regs("t7_a", 1, 3, 3, 0);
    #1 check("t7_pop0", 32'(head_pop), 32'b0001);
    @(negedge clk);
    chk_regs("t7_b", 1, 0, 0, 0);
    issue_ready = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1 check("t7_reset_pop", 32'(head_pop), 32'h0);
    @(negedge clk);
    chk_regs("t7_reset", 0, 0, 0, 0);
`ifdef ISSUE_SCHED_PERF_EN
    check("t7_perf_issued", 32'(perf_issued), 32'd0);
    check("t7_perf_sb", 32'(perf_sb_stalls), 32'd0);
`endif
    reset = 1'b0; issue_ready = 1'b1;
    #1 check("t7_first_pop", 32'(head_pop), 32'b0001);
    @(negedge clk);
    chk_regs("t7_first", 1, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vx_issue_sched.md
Name: vx_issue_sched

Overview:
- Per-core warp issue scheduler sitting between the per-warp instruction buffer heads and the scoreboard/dispatch path.
- Each cycle it picks one eligible warp:
  - valid head;
  - scoreboard clear;
  - target execute unit not back-pressuring.
- It pops that warp's head into a one-entry issue register presented to dispatch with valid/ready.
- Round-robin fairness, plus a starvation override that forces service of any warp left eligible too long.

Parameters:
- NUM_WARPS, 4, number of warps competing for issue (power of 2, >=2)
- EX_BITS, 3, width of execute-unit type code
- NUM_EX, 5, number of execute units (ALU, LSU, CSR, FPU, GPU)
- STARVE_LIMIT, 15, cycles an eligible-but-unserved warp waits before forced priority (1..255)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- head_valid  in  NUM_WARPS  per-warp instruction-buffer head valid
- head_ex_type  in  NUM_WARPS*EX_BITS  per-warp head execute-unit type; warp w at [w*EX_BITS +: EX_BITS]
- sb_ready  in  NUM_WARPS  per-warp scoreboard: head operands/rd hazard-free
- eu_ready  in  NUM_EX  per-execute-unit ready hint
- head_pop  out  NUM_WARPS  one-hot: pop selected warp's head this cycle
- issue_valid  out  1  issue register holds an instruction
- issue_wid  out  log2(NUM_WARPS)  warp id in issue register
- issue_ex_type  out  EX_BITS  execute type in issue register
- issue_ready  in  1  dispatch accepts issue register contents
- starve_active  out  1  current selection was forced by the starvation override

Behaviour:
- Reset values:
  - issue_valid=0, issue_wid=0, issue_ex_type=0, starve_active=0.
  - RR pointer=0; all wait counters=0.
  - head_pop=0 while reset is high.
- Eligibility: elig[w] = head_valid[w] & sb_ready[w] & eu_ready[head_ex_type[w]]. An ex_type >= NUM_EX is never eligible.
- Load condition: load = !issue_valid | issue_ready. Selection happens only when load is 1 and any elig is set.
- Selection priority:
  - (1) If any warp's wait counter >= STARVE_LIMIT and that warp is eligible, pick the lowest-index such warp and set starve_active=1 (registered alongside issue register).
  - (2) Otherwise round-robin: first eligible warp scanning from pointer upward, wrapping NUM_WARPS-1 -> 0.
- On select of warp s:
  - head_pop[s]=1 combinationally, same cycle.
  - Next edge: issue_valid=1, issue_wid=s, issue_ex_type=head_ex_type[s].
  - Pointer advances to (s+1) mod NUM_WARPS. It does not advance on a starvation pick.
- Drain with no new select: if issue_ready & issue_valid and nothing is eligible, issue_valid drops to 0 next edge.
- Hold: issue_valid & !issue_ready keeps issue_* stable, head_pop=0, no selection, and the pointer is frozen.
- Throughput: one issue per cycle sustained. Simultaneous accept and select reloads back-to-back with no bubble.
- Wait counters (8-bit, saturating at 255), per warp:
  - Clear when the warp is selected or not eligible.
  - Increment when eligible and not selected (including hold cycles).
- Latency: select to issue_valid = 1 cycle.
- Reset mid-operation: the in-flight issue register is discarded (issue_valid=0). The ibuffer is reset in the same cycle by the parent.

Optional Feature:
- Macro ISSUE_SCHED_PERF_EN.
- When defined, adds three outputs of PERF_CTR_BITS each, cleared on reset:
  - perf_sb_stalls: cycles with load=1, some head_valid & sb_ready clear for all valid heads.
  - perf_eu_stalls: cycles with load=1, some head_valid & sb_ready, none eligible.
  - perf_issued: count of selects.
- When undefined, the ports and counters are absent and there is no behavioural change.

Decomposition:
- Shared package: EX_* type codes, NUM_EX, the wid width function, PERF_CTR_BITS.
- One sub-module, vx_rr_pick: combinational rotate-priority picker (request vector, pointer -> one-hot grant, valid).

Test Plan:
- Reset then all four warps eligible, issue_ready=1 for 8 cycles -> issue_wid sequence 0,1,2,3,0,1,2,3; head_pop one-hot each cycle; no bubbles.
- Warp 2 only valid, sb_ready[2]=0 for 3 cycles then 1 -> no head_pop for 3 cycles, issue_valid rises 1 cycle after sb_ready; perf_sb_stalls=3 with ISSUE_SCHED_PERF_EN.
- issue_valid=1, issue_ready=0 for 5 cycles with warps eligible -> issue_wid/ex_type stable, head_pop=0, pointer unchanged; after ready, the next pick follows the old pointer.
- Warp 1's eu_ready deasserted (LSU busy) while warps 0/2 ALU run -> warp 1 never popped; after LSU is ready, warp 1 is issued within NUM_WARPS cycles.
- STARVE_LIMIT=3, warp 3 eligible while issue_ready toggles to keep RR landing elsewhere -> once counter reaches 3, warp 3 is issued with starve_active=1 and the pointer does not move.
- Reset asserted while issue_valid=1 -> next cycle issue_valid=0, counters 0, first post-reset pick is warp 0.
